dmem_sramlike_ctrl: RTL and testbench

//  Sequences CPU data-memory accesses from the MEM stage onto the sram-like data bus
//  (req/addr_ok/data_ok handshake). One outstanding access at a time.

---
 rtl/dmem_sramlike_ctrl.sv | 146 ++++++++++++++
 tb/tb_dmem_sramlike_ctrl.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_sramlike_ctrl.sv
// CPU data-memory sequencer onto an sram-like req/addr_ok/data_ok bus, one access outstanding.
// Latency: 2-cycle minimum stall; holds mem_stall until data_ok and parks the load word while longest_stall.
module dmem_sramlike_ctrl #(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              mem_en,
    input  logic              mem_wen,
    input  logic [1:0]        mem_size,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [31:0]       mem_wdata,
    input  logic              longest_stall,
    output logic [31:0]       mem_rdata,
    output logic              mem_stall,
    output logic              addr_err,
    output logic              data_req,
    output logic              data_wr,
    output logic [1:0]        data_size,
    output logic [ADDR_W-1:0] data_addr,
    output logic [31:0]       data_wdata,
    output logic [3:0]        data_wstrb,
    input  logic              data_addr_ok,
    input  logic              data_data_ok,
    input  logic [31:0]       data_rdata
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_DATA = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    state_t             r_state;
    logic               r_req;
    logic               r_wr;
    logic [1:0]         r_size;
    logic [ADDR_W-1:0]  r_addr;
    logic [31:0]        r_wdata;
    logic [3:0]         r_wstrb;
    logic [31:0]        r_rdata;

    logic               w_idle;
    logic               w_misalign;
    logic               w_start;
    logic [3:0]         w_strb;
    logic [31:0]        w_wdata;

    assign w_idle = (r_state == ST_IDLE);

    // Size 3 is decoded as a word everywhere (size >= 2).
    always_comb begin
        w_misalign = 1'b0;
        if (mem_size == 2'd1)
            w_misalign = mem_addr[0];
        else if (mem_size[1])
            w_misalign = (mem_addr[1:0] != 2'b00);
    end

    assign addr_err  = w_idle & mem_en & w_misalign;
    assign w_start   = w_idle & mem_en & ~w_misalign;
    assign mem_stall = w_start | (r_state == ST_ADDR) | (r_state == ST_DATA);

    // Store-extension datapath: strobes and lane replication from the right-aligned store data.
    always_comb begin
        w_strb  = 4'b0000;
        w_wdata = 32'h0;
        if (mem_wen) begin
            case (mem_size)
                2'd0: begin
                    w_strb  = 4'b0001 << mem_addr[1:0];
                    w_wdata = {4{mem_wdata[7:0]}};
                end
                2'd1: begin
                    w_strb  = mem_addr[1] ? 4'b1100 : 4'b0011;
                    w_wdata = {2{mem_wdata[15:0]}};
                end
                default: begin
                    w_strb  = 4'b1111;
                    w_wdata = mem_wdata;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_req   <= 1'b0;
            r_wr    <= 1'b0;
            r_size  <= 2'd0;
            r_addr  <= '0;
            r_wdata <= 32'h0;
            r_wstrb <= 4'b0000;
            r_rdata <= 32'h0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_start) begin
                        r_state <= ST_ADDR;
                        r_req   <= 1'b1;
                        r_wr    <= mem_wen;
                        r_size  <= mem_size;
                        r_addr  <= mem_addr;
                        r_wdata <= w_wdata;
                        r_wstrb <= w_strb;
                    end
                end
                ST_ADDR: begin
                    // A data_ok without addr_ok here belongs to nothing we issued.
                    if (data_addr_ok) begin
                        r_req <= 1'b0;
                        if (data_data_ok) begin
                            r_state <= ST_DONE;
                            r_rdata <= data_rdata;
                        end else begin
                            r_state <= ST_DATA;
                        end
                    end
                end
                ST_DATA: begin
                    if (data_data_ok) begin
                        r_state <= ST_DONE;
                        r_rdata <= data_rdata;
                    end
                end
                ST_DONE: begin
                    // The instruction is still in MEM here, so mem_en must not relaunch it.
                    if (!longest_stall)
                        r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign data_req   = r_req;
    assign data_wr    = r_wr;
    assign data_size  = r_size;
    assign data_addr  = r_addr;
    assign data_wdata = r_wdata;
    assign data_wstrb = r_wstrb;
    assign mem_rdata  = r_rdata;

endmodule

// File: tb/tb_dmem_sramlike_ctrl.sv
// Directed bench for dmem_sramlike_ctrl: store lanes, load latency, parking, misalign, reset, spurious data_ok.
module tb_dmem_sramlike_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_en, mem_wen, longest_stall;
    logic [1:0]  mem_size;
    logic [31:0] mem_addr, mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_stall, addr_err, data_req, data_wr;
    logic [1:0]  data_size;
    logic [31:0] data_addr, data_wdata;
    logic [3:0]  data_wstrb;
    logic        data_addr_ok, data_data_ok;
    logic [31:0] data_rdata;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    dmem_sramlike_ctrl #(.ADDR_W(32)) dut (
        .clk(clk), .rst(rst),
        .mem_en(mem_en), .mem_wen(mem_wen), .mem_size(mem_size),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .longest_stall(longest_stall),
        .mem_rdata(mem_rdata), .mem_stall(mem_stall), .addr_err(addr_err),
        .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
        .data_addr(data_addr), .data_wdata(data_wdata), .data_wstrb(data_wstrb),
        .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok), .data_rdata(data_rdata)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=%h expected=%h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic wen, input logic [1:0] size,
                         input logic [31:0] addr, input logic [31:0] wdata);
        mem_en    = 1'b1;
        mem_wen   = wen;
        mem_size  = size;
        mem_addr  = addr;
        mem_wdata = wdata;
    endtask

    // Store-lane vectors: size, addr, wdata, expected strobe, expected bus data.
    typedef struct {
        logic [1:0]  size;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  strb;
        logic [31:0] bus;
    } vec_t;
    vec_t vecs[4];

    int req_cycles;

    initial begin
        vecs[0] = '{2'd0, 32'h0000_1001, 32'hFFFF_FF5A, 4'b0010, 32'h5A5A_5A5A};
        vecs[1] = '{2'd1, 32'h0000_1000, 32'hAAAA_BEEF, 4'b0011, 32'hBEEF_BEEF};
        vecs[2] = '{2'd2, 32'h0000_4000, 32'h89AB_CDEF, 4'b1111, 32'h89AB_CDEF};
        vecs[3] = '{2'd3, 32'h0000_4008, 32'h0123_4567, 4'b1111, 32'h0123_4567};

        rst = 1'b1;
        mem_en = 0; mem_wen = 0; mem_size = 0; mem_addr = 0; mem_wdata = 0;
        longest_stall = 0; data_addr_ok = 0; data_data_ok = 0; data_rdata = 0;
        #12;
        check_eq("rst_req", {31'b0, data_req}, 32'd0);
        check_eq("rst_stall", {31'b0, mem_stall}, 32'd0);
        check_eq("rst_rdata", mem_rdata, 32'd0);
        check_eq("rst_strb", {28'b0, data_wstrb}, 32'd0);
        tick();
        rst = 1'b0;
        tick();

        // 1: sb to lane 3, immediate addr_ok+data_ok
        issue(1'b1, 2'd0, 32'h0000_1003, 32'h0000_00AB);
        #1;
        check_eq("t1_stall_c0", {31'b0, mem_stall}, 32'd1);
        check_eq("t1_req_c0", {31'b0, data_req}, 32'd0);
        tick();
        data_addr_ok = 1; data_data_ok = 1;
        #1;
        check_eq("t1_req_c1", {31'b0, data_req}, 32'd1);
        check_eq("t1_stall_c1", {31'b0, mem_stall}, 32'd1);
        check_eq("t1_wr", {31'b0, data_wr}, 32'd1);
        check_eq("t1_strb", {28'b0, data_wstrb}, 32'h8);
        check_eq("t1_wdata", data_wdata, 32'hABAB_ABAB);
        check_eq("t1_addr", data_addr, 32'h0000_1003);
        tick();
        data_addr_ok = 0; data_data_ok = 0;
        #1;
        check_eq("t1_stall_done", {31'b0, mem_stall}, 32'd0);
        check_eq("t1_req_done", {31'b0, data_req}, 32'd0);
        tick();
        mem_en = 0;
        tick();

        // 2: lw, addr_ok on 4th req cycle, data_ok two cycles later
        issue(1'b0, 2'd2, 32'h0000_2000, 32'hFFFF_FFFF);
        tick();
        #1;
        check_eq("t2_wr", {31'b0, data_wr}, 32'd0);
        check_eq("t2_strb", {28'b0, data_wstrb}, 32'd0);
        check_eq("t2_wdata", data_wdata, 32'd0);
        check_eq("t2_size", {30'b0, data_size}, 32'd2);
        req_cycles = 0;
        for (int c = 1; c <= 6; c++) begin
            data_addr_ok = (c == 4);
            #1;
            if (data_req) req_cycles++;
            tick();
        end
        data_addr_ok = 0;
        check_eq("t2_req_cycles", req_cycles, 32'd4);
        check_eq("t2_stall_data", {31'b0, mem_stall}, 32'd1);
        data_data_ok = 1; data_rdata = 32'hDEAD_BEEF;
        tick();
        data_data_ok = 0; data_rdata = 32'h0;
        #1;
        check_eq("t2_rdata", mem_rdata, 32'hDEAD_BEEF);
        check_eq("t2_stall_done", {31'b0, mem_stall}, 32'd0);
        tick();
        mem_en = 0;
        tick();

        // 3: load parked in DONE under longest_stall, no relaunch
        issue(1'b0, 2'd2, 32'h0000_3004, 32'h0);
        tick();
        data_addr_ok = 1; data_data_ok = 1; data_rdata = 32'h1234_5678;
        tick();
        data_addr_ok = 0; data_data_ok = 0; data_rdata = 32'hFFFF_FFFF;
        longest_stall = 1;
        req_cycles = 0;
        for (int c = 0; c < 5; c++) begin
            #1;
            if (data_req || mem_stall) req_cycles++;
            check_eq("t3_rdata_held", mem_rdata, 32'h1234_5678);
            tick();
        end
        check_eq("t3_no_relaunch", req_cycles, 32'd0);
        longest_stall = 0;
        tick();
        mem_en = 0;
        #1;
        check_eq("t3_idle_stall", {31'b0, mem_stall}, 32'd0);
        check_eq("t3_idle_req", {31'b0, data_req}, 32'd0);
        tick();

        // 4: misaligned half, then aligned upper half
        issue(1'b1, 2'd1, 32'h0000_1001, 32'h0000_1234);
        #1;
        check_eq("t4_addr_err", {31'b0, addr_err}, 32'd1);
        check_eq("t4_err_stall", {31'b0, mem_stall}, 32'd0);
        req_cycles = 0;
        for (int c = 0; c < 3; c++) begin
            tick();
            #1;
            if (data_req) req_cycles++;
        end
        check_eq("t4_err_noreq", req_cycles, 32'd0);
        mem_addr = 32'h0000_1002;
        #1;
        check_eq("t4_ok_err", {31'b0, addr_err}, 32'd0);
        tick();
        data_addr_ok = 1; data_data_ok = 1;
        #1;
        check_eq("t4_strb", {28'b0, data_wstrb}, 32'hC);
        check_eq("t4_wdata", data_wdata, 32'h1234_1234);
        tick();
        data_addr_ok = 0; data_data_ok = 0;
        tick();
        mem_en = 0;
        tick();

        // store-lane table
        foreach (vecs[i]) begin
            issue(1'b1, vecs[i].size, vecs[i].addr, vecs[i].wdata);
            tick();
            data_addr_ok = 1; data_data_ok = 1;
            #1;
            check_eq($sformatf("tbl%0d_strb", i), {28'b0, data_wstrb}, {28'b0, vecs[i].strb});
            check_eq($sformatf("tbl%0d_wdata", i), data_wdata, vecs[i].bus);
            check_eq($sformatf("tbl%0d_size", i), {30'b0, data_size}, {30'b0, vecs[i].size});
            tick();
            data_addr_ok = 0; data_data_ok = 0;
            tick();
            mem_en = 0;
            tick();
        end

        // 5: async reset while in DATA
        issue(1'b0, 2'd2, 32'h0000_5000, 32'h0);
        tick();
        data_addr_ok = 1;
        tick();
        data_addr_ok = 0;
        mem_en = 0;
        #1;
        check_eq("t5_in_data", {31'b0, mem_stall}, 32'd1);
        rst = 1'b1;
        #1;
        check_eq("t5_rst_req", {31'b0, data_req}, 32'd0);
        check_eq("t5_rst_stall", {31'b0, mem_stall}, 32'd0);
        check_eq("t5_rst_rdata", mem_rdata, 32'd0);
        tick();
        rst = 1'b0;
        tick();

        // 6: spurious data_ok while waiting for addr_ok
        issue(1'b0, 2'd2, 32'h0000_6000, 32'h0);
        tick();
        data_data_ok = 1; data_rdata = 32'hBAD0_BAD0;
        tick();
        data_data_ok = 0; data_rdata = 32'h0;
        #1;
        check_eq("t6_still_req", {31'b0, data_req}, 32'd1);
        check_eq("t6_no_capture", mem_rdata, 32'd0);
        data_addr_ok = 1;
        tick();
        data_addr_ok = 0;
        #1;
        check_eq("t6_data_stall", {31'b0, mem_stall}, 32'd1);
        check_eq("t6_data_noreq", {31'b0, data_req}, 32'd0);
        data_data_ok = 1; data_rdata = 32'hCAFE_F00D;
        tick();
        data_data_ok = 0; data_rdata = 32'h0;
        #1;
        check_eq("t6_rdata", mem_rdata, 32'hCAFE_F00D);
        check_eq("t6_done_stall", {31'b0, mem_stall}, 32'd0);
        tick();
        mem_en = 0;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
